// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick scheduler: FSM state encoding and period normalisation.
package tick_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // A programmed period of 0 behaves as 1 (tick on every base tick).
  function automatic int unsigned period_eff(input int unsigned period);
    return (period == 0) ? 1 : period;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: counts base-tick wraps and emits a one-cycle tick per period.
module tick_channel
  import tick_pkg::*;
#(
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wrap,
  input  logic             load,
  input  logic             cfg_en,
  input  logic [PER_W-1:0] cfg_period,
  output logic             tick
);

  logic             en;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] count;

  // A config load takes priority over a coincident wrap, so that wrap's tick is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      period <= PER_W'(1);
      count  <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        en     <= cfg_en;
        period <= PER_W'(period_eff(32'(cfg_period)));
        count  <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (wrap && en) begin
        if (count == period - PER_W'(1)) begin
          count <= '0;
          tick  <= 1'b1;
        end else begin
          count <= count + PER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler, run/stop FSM and config handshake driving N_CH tick channels on CLK.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int PRESCALE = 4194304,
  parameter int N_CH     = 4,
  parameter int PER_W    = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_en,
  input  logic [PER_W-1:0] cfg_period,
  output logic             base_tick,
  output logic [N_CH-1:0]  tick,
  output logic             running
);

  localparam int PS_W = $clog2(PRESCALE);

  state_t          state;
  state_t          state_d;
  logic [PS_W-1:0] presc;
  logic            wrap;
  logic            stay_run;
  logic            accept;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign running  = (state == ST_RUN);
  assign stay_run = (state == ST_RUN) && (state_d == ST_RUN);
  // A wrap in the cycle that leaves RUN is discarded along with the counts.
  assign wrap     = stay_run && (presc == PS_W'(PRESCALE - 1));
  assign accept   = cfg_valid && cfg_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc     <= '0;
      base_tick <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      base_tick <= wrap;
      cfg_ready <= !accept;
      if (!stay_run || wrap) presc <= '0;
      else                   presc <= presc + PS_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tick_channel #(.PER_W(PER_W)) u_ch (
      .clk        (CLK),
      .reset      (RESET),
      .clear      (!stay_run),
      .wrap       (wrap),
      .load       (accept && (cfg_ch == CH_W'(i))),
      .cfg_en     (cfg_en),
      .cfg_period (cfg_period),
      .tick       (tick[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: cycle-by-cycle vector table plus a 3-channel variant.
module tb_tick_scheduler;

  logic       CLK = 1'b0;
  logic       RESET, run, cfg_valid, cfg_en;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_ready, base_tick, running;
  logic [3:0] tick;

  logic       rst3, run3, v3, en3;
  logic [1:0] ch3;
  logic [7:0] per3;
  logic       ready3, bt3, running3;
  logic [2:0] tick3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  tick_scheduler #(.PRESCALE(4), .N_CH(4), .PER_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_period(cfg_period),
    .base_tick(base_tick), .tick(tick), .running(running)
  );

  tick_scheduler #(.PRESCALE(2), .N_CH(3), .PER_W(8)) dut3 (
    .CLK(CLK), .RESET(rst3), .run(run3), .cfg_valid(v3), .cfg_ready(ready3),
    .cfg_ch(ch3), .cfg_en(en3), .cfg_period(per3),
    .base_tick(bt3), .tick(tick3), .running(running3)
  );

  typedef struct {
    logic       rst, rn_in, v;
    logic [1:0] ch;
    logic       en;
    logic [7:0] per;
    logic       bt;
    logic [3:0] tk;
    logic       rn, rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rn_in, input logic v, input logic [1:0] ch,
                     input logic en, input logic [7:0] per, input logic bt,
                     input logic [3:0] tk, input logic rn, input logic rdy);
    vec_t r;
    r.rst = rst; r.rn_in = rn_in; r.v = v; r.ch = ch; r.en = en; r.per = per;
    r.bt = bt; r.tk = tk; r.rn = rn; r.rdy = rdy;
    vecs.push_back(r);
  endtask

  task automatic plain_run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int bt_n;
    int tk_n;

    // Reset held 3 cycles, then 20 idle cycles with run=0.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
    // cfg_valid held through three transfers while idle: accepts every other cycle.
    add(0, 0, 1, 0, 1, 8'd1, 0, 4'b0000, 0, 0);
    add(0, 0, 1, 1, 1, 8'd3, 0, 4'b0000, 0, 1);
    add(0, 0, 1, 1, 1, 8'd3, 0, 4'b0000, 0, 0);
    add(0, 0, 1, 2, 1, 8'd0, 0, 4'b0000, 0, 1);
    add(0, 0, 1, 2, 1, 8'd0, 0, 4'b0000, 0, 0);
    // Start: running next edge, base_tick every 4 cycles; ch1 on every 3rd base tick.
    add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0101, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0101, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0111, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0101, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0101, 1, 1);
    // 6th base tick: reconfigure ch1 to period 2 in the wrap cycle, its tick is dropped.
    plain_run(3); add(0, 1, 1, 1, 1, 8'd2, 1, 4'b0101, 1, 0);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0101, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0111, 1, 1);
    // Stop exactly in a wrap cycle: that wrap is ignored.
    plain_run(3); add(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
    // Restart from cleared counts.
    add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0101, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0111, 1, 1);
    // Reset mid-period with run held high; channels come back disabled.
    plain_run(1);
    add(1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 1);
    plain_run(3); add(0, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 1);

    rst3 = 1'b1; run3 = 1'b0; v3 = 1'b0; ch3 = '0; en3 = 1'b0; per3 = '0;

    foreach (vecs[k]) begin
      RESET = vecs[k].rst; run = vecs[k].rn_in; cfg_valid = vecs[k].v;
      cfg_ch = vecs[k].ch; cfg_en = vecs[k].en; cfg_period = vecs[k].per;
      @(posedge CLK); #1;
      check("base_tick", k, 32'(base_tick), 32'(vecs[k].bt));
      check("tick",      k, 32'(tick),      32'(vecs[k].tk));
      check("running",   k, 32'(running),   32'(vecs[k].rn));
      check("cfg_ready", k, 32'(cfg_ready), 32'(vecs[k].rdy));
    end

    // 3-channel variant: cfg_ch=3 is accepted but changes nothing.
    @(posedge CLK); #1;
    check("v3_reset_ready", 0, 32'(ready3), 32'd0);
    check("v3_reset_tick",  0, 32'(tick3), 32'd0);
    rst3 = 1'b0;
    @(posedge CLK); #1;
    check("v3_ready_rise", 0, 32'(ready3), 32'd1);
    v3 = 1'b1; ch3 = 2'd3; en3 = 1'b1; per3 = 8'd1;
    @(posedge CLK); #1;
    check("v3_invalid_accepted", 0, 32'(ready3), 32'd0);
    v3 = 1'b0;
    @(posedge CLK); #1;
    check("v3_ready_back", 0, 32'(ready3), 32'd1);
    run3 = 1'b1;
    @(posedge CLK); #1;
    check("v3_running", 0, 32'(running3), 32'd1);
    bt_n = 0; tk_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (bt3) bt_n++;
      if (tick3 != 3'b000) tk_n++;
    end
    check("v3_base_ticks", 0, 32'(bt_n), 32'd4);
    check("v3_no_ticks",   0, 32'(tk_n), 32'd0);
    v3 = 1'b1; ch3 = 2'd2; en3 = 1'b1; per3 = 8'd0;
    @(posedge CLK); #1;
    v3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      check("v3_bt_phase", i, 32'(bt3),   (i % 2 == 0) ? 32'd1 : 32'd0);
      check("v3_ch2_tick", i, 32'(tick3), (i % 2 == 0) ? 32'h4 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
